id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that directly feeds the ALU.
- Captures decoded instructions and resolves operand bypassing from the ALU result (EX) and the writeback result (WB).
- Detects load-use hazards and inserts bubbles.
- Valid/ready handshake on both sides; downstream backpressure holds the stage.

Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  kill held and incoming instruction (branch/trap redirect)
- id_valid  input  1  decode presents an instruction
- id_ready  output  1  stage accepts decode instruction this cycle
- id_pc  input  data_t  instruction PC
- id_alu_op  input  alu_op_t  ALU operator
- id_rs1_addr  input  REG_ADDR_WIDTH  source 1 address; decode drives 0 when unused
- id_rs2_addr  input  REG_ADDR_WIDTH  source 2 address; decode drives 0 when unused
- id_rs1_data  input  data_t  register-file read 1
- id_rs2_data  input  data_t  register-file read 2
- id_imm  input  data_t  sign-extended immediate
- id_op_sel  input  2  bit0: operand1 = PC; bit1: operand2 = imm
- id_rd_addr  input  REG_ADDR_WIDTH  destination
- id_rd_we  input  1  destination written
- id_is_load  input  1  instruction is a load
- alu_result  input  data_t  ALU out for the instruction held here
- wb_rd_addr  input  REG_ADDR_WIDTH  writeback destination
- wb_rd_we  input  1  writeback valid write
- wb_rd_data  input  data_t  writeback data
- ex_valid  output  1  held instruction valid
- ex_ready  input  1  downstream consumes held instruction
- ex_alu_op  output  alu_op_t  to ALU operator
- ex_operand1  output  data_t  to ALU operand1
- ex_operand2  output  data_t  to ALU operand2
- ex_store_data  output  data_t  forwarded rs2 value
- ex_rd_addr / ex_rd_we / ex_is_load  output  REG_ADDR_WIDTH/1/1  destination info

Behaviour:
- Reset: all outputs registered 0 (ex_valid=0, ex_alu_op=0, operands/store_data/rd fields 0).
- advance = !ex_valid || ex_ready.
- load_use = ex_valid && ex_is_load && ex_rd_we && ex_rd_addr!=0 && (ex_rd_addr==id_rs1_addr || ex_rd_addr==id_rs2_addr).
- id_ready = advance && !load_use && !flush (combinational).
- Per-source forward value, priority highest first:
  - EX: ex_valid && ex_rd_we && !ex_is_load && ex_rd_addr==rs && rs!=0 → alu_result.
  - WB: wb_rd_we && wb_rd_addr==rs && rs!=0 → wb_rd_data.
  - Otherwise: id_rsN_data.
  - Address 0 never forwarded and never stalls.
- Capture on posedge:
  - flush: ex_valid<=0 (flush beats stall and backpressure).
  - Else if advance: ex_valid<=id_valid && !load_use; fields load from decode.
  - Else: hold all registers.
- Captured operands:
  - ex_operand1 = id_op_sel[0] ? id_pc : fwd1.
  - ex_operand2 = id_op_sel[1] ? id_imm : fwd2.
  - ex_store_data = fwd2.
- Bubble: when load_use, fields may load but ex_valid=0. Next cycle the load sits in WB and its data comes from wb_rd_data.
- Latency: 1 cycle, decode handshake to ex_valid; throughput 1/cycle without hazards.
- Forwarding from EX is sampled only on advance; the held producer leaves the same edge.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits), reset 0.
  - Increments each cycle id_valid && load_use && !flush; wraps 0xFFFFFFFF→0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- ADD x3,x1,x2 (x1=5, x2=7 regfile), ex_ready=1 → next cycle ex_valid=1, operand1=5, operand2=7, rd=3.
- EX forwarding: ADD x3 held, alu_result=12; next SUB x4,x3,x1 → operand1=12, not the stale regfile value.
- EX and WB both write x3: alu_result=9, wb_rd_data=4 → operand1=9 (EX priority). rs=x0 with wb_rd_addr=0, wb_rd_data=0xFFFF → operand1=0.
- LW x5 held, next ADD x6,x5,x1:
  - id_ready=0 for one cycle; one bubble (ex_valid=0).
  - Then operand1=wb_rd_data=0xDEAD.
  - stall_cnt=1 when ID_EX_PERF_CNT_EN.
- ex_ready=0 for 3 cycles with id_valid=1 → outputs stable, id_ready=0; ex_ready=1 → next instruction captured.
- flush=1 with ex_ready=0 and id_valid=1 → next cycle ex_valid=0, id_ready was 0. rst=1 mid-stream → next cycle all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register that feeds the ALU.
// It resolves operand bypassing from EX (alu_result) and WB (wb_rd_data),
// inserts a bubble on a load-use hazard, and uses a valid/ready handshake
// on both sides, with downstream backpressure holding the stage.
// Optional feature: define ID_EX_PERF_CNT_EN to add the 32-bit stall_cnt output,
// which counts the cycles a valid decode instruction is held off by a load-use hazard.

package id_ex_pkg;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  alu_op_t;
endpackage

module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    // decode side
    input  logic                      id_valid,
    output logic                      id_ready,
    input  data_t                     id_pc,
    input  alu_op_t                   id_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  data_t                     id_rs1_data,
    input  data_t                     id_rs2_data,
    input  data_t                     id_imm,
    input  logic [1:0]                id_op_sel,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_rd_we,
    input  logic                      id_is_load,
    // bypass sources
    input  data_t                     alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                      wb_rd_we,
    input  data_t                     wb_rd_data,
    // execute side
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output alu_op_t                   ex_alu_op,
    output data_t                     ex_operand1,
    output data_t                     ex_operand2,
    output data_t                     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_rd_we,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]               stall_cnt,
`endif
    output logic                      ex_is_load
);

    // Held instruction state
    logic                      valid_q,    valid_d;
    alu_op_t                   alu_op_q,   alu_op_d;
    data_t                     op1_q,      op1_d;
    data_t                     op2_q,      op2_d;
    data_t                     store_q,    store_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
    logic                      rd_we_q,    rd_we_d;
    logic                      is_load_q,  is_load_d;

    logic  advance;
    logic  load_use;
    logic  ex_fwd_ok;
    logic  wb_fwd_ok;
    data_t fwd1;
    data_t fwd2;

    // The stage can take a new instruction when empty or when the held one leaves.
    assign advance = !valid_q || ex_ready;

    // A held load cannot supply its data until it reaches WB, so a dependent
    // instruction waits one cycle behind a bubble.
    assign load_use = valid_q && is_load_q && rd_we_q && (rd_addr_q != '0) &&
                      ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));

    assign id_ready = advance && !load_use && !flush;

    // Bypass sources are qualified once; register 0 is never a bypass target.
    assign ex_fwd_ok = valid_q && rd_we_q && !is_load_q && (rd_addr_q != '0);
    assign wb_fwd_ok = wb_rd_we && (wb_rd_addr != '0);

    // Select the freshest value for each source register, with EX ahead of WB.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fwd1 = id_rs1_data;
        fwd2 = id_rs2_data;
        if (ex_fwd_ok && (rd_addr_q == id_rs1_addr)) begin
            fwd1 = alu_result;
        end else if (wb_fwd_ok && (wb_rd_addr == id_rs1_addr)) begin
            fwd1 = wb_rd_data;
        end
        if (ex_fwd_ok && (rd_addr_q == id_rs2_addr)) begin
            fwd2 = alu_result;
        end else if (wb_fwd_ok && (wb_rd_addr == id_rs2_addr)) begin
            fwd2 = wb_rd_data;
        end
    end

    // Next-state: a flush kills the held instruction, advance loads, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        alu_op_d  = alu_op_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        store_d   = store_q;
        rd_addr_d = rd_addr_q;
        rd_we_d   = rd_we_q;
        is_load_d = is_load_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            // On a load-use bubble the fields still load; only valid is suppressed.
            valid_d   = id_valid && !load_use;
            alu_op_d  = id_alu_op;
            op1_d     = id_op_sel[0] ? id_pc  : fwd1;
            op2_d     = id_op_sel[1] ? id_imm : fwd2;
            store_d   = fwd2;
            rd_addr_d = id_rd_addr;
            rd_we_d   = id_rd_we;
            is_load_d = id_is_load;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every field, not just valid, so outputs read 0 after reset.
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            valid_q   <= 1'b0;
            alu_op_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            store_q   <= '0;
            rd_addr_q <= '0;
            rd_we_q   <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            alu_op_q  <= alu_op_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            store_q   <= store_d;
            rd_addr_q <= rd_addr_d;
            rd_we_q   <= rd_we_d;
            is_load_q <= is_load_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_operand1   = op1_q;
    assign ex_operand2   = op2_q;
    assign ex_store_data = store_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_rd_we      = rd_we_q;
    assign ex_is_load    = is_load_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count the cycles a presented instruction is held off by a load-use hazard; wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (id_valid && load_use && !flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a directed vector table for the
// main scenarios, a mid-stream reset, then randomized traffic compared
// against a transaction-level model of the stage.
module tb_id_ex_stage;
    import id_ex_pkg::*;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    data_t         id_pc;
    alu_op_t       id_alu_op;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    data_t         id_rs1_data, id_rs2_data, id_imm;
    logic [1:0]    id_op_sel;
    logic          id_rd_we, id_is_load;
    data_t         alu_result;
    logic [AW-1:0] wb_rd_addr;
    logic          wb_rd_we;
    data_t         wb_rd_data;
    logic          ex_valid, ex_ready;
    alu_op_t       ex_alu_op;
    data_t         ex_operand1, ex_operand2, ex_store_data;
    logic [AW-1:0] ex_rd_addr;
    logic          ex_rd_we, ex_is_load;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_alu_op(id_alu_op),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_op_sel(id_op_sel),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .alu_result(alu_result),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .ex_is_load(ex_is_load)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One directed cycle: inputs plus what id_ready must be before the edge
    // and what the held instruction must look like after it.
    typedef struct {
        logic          flush, id_valid, ex_ready;
        logic [AW-1:0] rs1, rs2, rd;
        data_t         rs1_data, rs2_data, pc, imm;
        logic [1:0]    op_sel;
        logic          we, is_load;
        data_t         alu_res;
        logic [AW-1:0] wb_addr;
        logic          wb_we;
        data_t         wb_data;
        logic          exp_ready, exp_valid, chk_fields;
        data_t         exp_op1, exp_op2;
        logic [AW-1:0] exp_rd;
    } vec_t;

    function automatic vec_t base();
        vec_t v;
        v.flush = 0; v.id_valid = 1; v.ex_ready = 1;
        v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.rs1_data = 0; v.rs2_data = 0;
        v.pc = 32'h100; v.imm = 0; v.op_sel = 2'b00; v.we = 1; v.is_load = 0;
        v.alu_res = 0; v.wb_addr = 0; v.wb_we = 0; v.wb_data = 0;
        v.exp_ready = 1; v.exp_valid = 1; v.chk_fields = 1;
        v.exp_op1 = 0; v.exp_op2 = 0; v.exp_rd = 0;
        return v;
    endfunction

    task automatic drive_idle();
        flush = 0; id_valid = 0; ex_ready = 1; id_pc = 0; id_alu_op = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_op_sel = 0; id_rd_addr = 0; id_rd_we = 0; id_is_load = 0;
        alu_result = 0; wb_rd_addr = 0; wb_rd_we = 0; wb_rd_data = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, "_ex_alu_op"}, {28'd0, ex_alu_op}, 32'd0);
        check({tag, "_ex_operand1"}, ex_operand1, 32'd0);
        check({tag, "_ex_operand2"}, ex_operand2, 32'd0);
        check({tag, "_ex_store_data"}, ex_store_data, 32'd0);
        check({tag, "_ex_rd"}, {ex_is_load, ex_rd_we, 25'd0, ex_rd_addr}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        flush = v.flush; id_valid = v.id_valid; ex_ready = v.ex_ready;
        id_pc = v.pc; id_alu_op = 4'h1; id_imm = v.imm; id_op_sel = v.op_sel;
        id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
        id_rs1_data = v.rs1_data; id_rs2_data = v.rs2_data;
        id_rd_addr = v.rd; id_rd_we = v.we; id_is_load = v.is_load;
        alu_result = v.alu_res; wb_rd_addr = v.wb_addr; wb_rd_we = v.wb_we; wb_rd_data = v.wb_data;
        #1;
        check({tag, "_id_ready"}, {31'd0, id_ready}, {31'd0, v.exp_ready});
        @(posedge clk); #1;
        check({tag, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, v.exp_valid});
        if (v.chk_fields) begin
            check({tag, "_operand1"}, ex_operand1, v.exp_op1);
            check({tag, "_operand2"}, ex_operand2, v.exp_op2);
            check({tag, "_rd_addr"}, {27'd0, ex_rd_addr}, {27'd0, v.exp_rd});
        end
    endtask

    // Transaction-level model: the stage either holds one instruction or is empty.
    typedef struct {
        logic          valid;
        alu_op_t       op;
        data_t         op1, op2, sd;
        logic [AW-1:0] rd;
        logic          we, ld;
    } held_t;

    held_t       m;
    logic [31:0] m_cnt;

    // Newest in-flight producer of rs wins; x0 always reads the register file value.
    function automatic data_t ref_value(input logic [AW-1:0] rs, input data_t rf);
        if (rs == 0) return rf;
        if (m.valid && m.we && !m.ld && m.rd == rs) return alu_result;
        if (wb_rd_we && wb_rd_addr == rs) return wb_rd_data;
        return rf;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        held_t nx;
        logic hazard, can_move;

        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 0;

        // 0: ADD x3,x1,x2 with x1=5, x2=7
        v = base(); v.rs1 = 1; v.rs1_data = 5; v.rs2 = 2; v.rs2_data = 7; v.rd = 3;
        v.exp_op1 = 5; v.exp_op2 = 7; v.exp_rd = 3; tbl.push_back(v);
        // 1: SUB x4,x3,x1 takes x3 from EX, not the stale register file
        v = base(); v.rs1 = 3; v.rs1_data = 100; v.rs2 = 1; v.rs2_data = 5; v.rd = 4; v.alu_res = 12;
        v.exp_op1 = 12; v.exp_op2 = 5; v.exp_rd = 4; tbl.push_back(v);
        // 2: EX and WB both write x4: EX wins
        v = base(); v.rs1 = 4; v.rs1_data = 50; v.rd = 5; v.alu_res = 9;
        v.wb_addr = 4; v.wb_we = 1; v.wb_data = 4;
        v.exp_op1 = 9; v.exp_op2 = 0; v.exp_rd = 5; tbl.push_back(v);
        // 3: x0 is never forwarded even when WB targets x0
        v = base(); v.rd = 6; v.alu_res = 32'h1234; v.wb_addr = 0; v.wb_we = 1; v.wb_data = 32'hFFFF;
        v.exp_op1 = 0; v.exp_op2 = 0; v.exp_rd = 6; tbl.push_back(v);
        // 4: LW x5 using PC and immediate selects
        v = base(); v.rd = 5; v.is_load = 1; v.op_sel = 2'b11; v.pc = 32'h40; v.imm = 32'h10;
        v.exp_op1 = 32'h40; v.exp_op2 = 32'h10; v.exp_rd = 5; tbl.push_back(v);
        // 5: ADD x6,x5,x1 behind the load: stall, bubble
        v = base(); v.rs1 = 5; v.rs1_data = 32'h77; v.rs2 = 1; v.rs2_data = 5; v.rd = 6;
        v.exp_ready = 0; v.exp_valid = 0; v.chk_fields = 0; tbl.push_back(v);
        // 6: same ADD, load now in WB
        v = base(); v.rs1 = 5; v.rs1_data = 32'h77; v.rs2 = 1; v.rs2_data = 5; v.rd = 6;
        v.wb_addr = 5; v.wb_we = 1; v.wb_data = 32'hDEAD;
        v.exp_op1 = 32'hDEAD; v.exp_op2 = 5; v.exp_rd = 6; tbl.push_back(v);
        // 7..9: backpressure holds the ADD for three cycles
        for (int i = 0; i < 3; i++) begin
            v = base(); v.ex_ready = 0; v.rs1 = 1; v.rs1_data = 1; v.rs2 = 2; v.rs2_data = 2; v.rd = 7;
            v.alu_res = 32'h5555 + i;
            v.exp_ready = 0; v.exp_op1 = 32'hDEAD; v.exp_op2 = 5; v.exp_rd = 6; tbl.push_back(v);
        end
        // 10: release: next instruction captured
        v = base(); v.rs1 = 1; v.rs1_data = 1; v.rs2 = 2; v.rs2_data = 2; v.rd = 7;
        v.exp_op1 = 1; v.exp_op2 = 2; v.exp_rd = 7; tbl.push_back(v);
        // 11: flush under backpressure with a presented instruction
        v = base(); v.flush = 1; v.ex_ready = 0; v.rs1 = 1; v.rs1_data = 9; v.rd = 8;
        v.exp_ready = 0; v.exp_valid = 0; v.chk_fields = 0; tbl.push_back(v);
        // 12: flow resumes after the flush
        v = base(); v.rs1 = 1; v.rs1_data = 3; v.rd = 8;
        v.exp_op1 = 3; v.exp_op2 = 0; v.exp_rd = 8; tbl.push_back(v);

        foreach (tbl[i]) apply(i, tbl[i]);

`ifdef ID_EX_PERF_CNT_EN
        check("stall_cnt_after_load_use", stall_cnt, 32'd1);
`endif

        // Mid-stream reset with an instruction being presented
        v = base(); v.rs1 = 1; v.rs1_data = 32'hABCD; v.rd = 9;
        id_valid = 1; id_rs1_addr = 1; id_rs1_data = 32'hABCD; id_rd_addr = 9; id_rd_we = 1;
        rst = 1;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        rst = 0;

        // Randomized traffic against the model
        m = '{valid: 1'b0, op: '0, op1: '0, op2: '0, sd: '0, rd: '0, we: 1'b0, ld: 1'b0};
        m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush       = ($urandom_range(0, 15) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            id_pc       = $urandom;
            id_alu_op   = alu_op_t'($urandom_range(0, 15));
            id_rs1_addr = AW'($urandom_range(0, 3));
            id_rs2_addr = AW'($urandom_range(0, 3));
            id_rs1_data = $urandom;
            id_rs2_data = $urandom;
            id_imm      = $urandom;
            id_op_sel   = 2'($urandom_range(0, 3));
            id_rd_addr  = AW'($urandom_range(0, 3));
            id_rd_we    = ($urandom_range(0, 3) != 0);
            id_is_load  = ($urandom_range(0, 2) == 0);
            alu_result  = $urandom;
            wb_rd_addr  = AW'($urandom_range(0, 3));
            wb_rd_we    = $urandom_range(0, 1) == 1;
            wb_rd_data  = $urandom;
            #1;
            hazard   = m.valid && m.ld && m.we && (m.rd != 0) &&
                       (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
            can_move = !m.valid || ex_ready;
            check("rand_id_ready", {31'd0, id_ready}, {31'd0, can_move && !hazard && !flush});

            nx = m;
            if (flush) begin
                nx.valid = 0;
            end else if (can_move) begin
                nx.valid = id_valid && !hazard;
                nx.op    = id_alu_op;
                nx.op1   = id_op_sel[0] ? id_pc  : ref_value(id_rs1_addr, id_rs1_data);
                nx.op2   = id_op_sel[1] ? id_imm : ref_value(id_rs2_addr, id_rs2_data);
                nx.sd    = ref_value(id_rs2_addr, id_rs2_data);
                nx.rd    = id_rd_addr;
                nx.we    = id_rd_we;
                nx.ld    = id_is_load;
            end
            if (id_valid && hazard && !flush) m_cnt = m_cnt + 1;

            @(posedge clk); #1;
            m = nx;
            check("rand_ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            if (m.valid) begin
                check("rand_alu_op", {28'd0, ex_alu_op}, {28'd0, m.op});
                check("rand_operand1", ex_operand1, m.op1);
                check("rand_operand2", ex_operand2, m.op2);
                check("rand_store_data", ex_store_data, m.sd);
                check("rand_rd", {ex_is_load, ex_rd_we, 25'd0, ex_rd_addr},
                      {m.ld, m.we, 25'd0, m.rd});
            end
        end
`ifdef ID_EX_PERF_CNT_EN
        check("rand_stall_cnt", stall_cnt, m_cnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
